// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: oversampled UART receiver (3-sample majority vote, frame check) feeding a
// valid/ready receive FIFO. Define SERIAL_RX_PARITY_EN to add a checked parity bit after the data.
module serial_rx_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 57600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk25,
    input  logic                 rst_n,
    input  logic                 serrx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [FIFO_AW:0]     count,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [2:0]           err_sticky,
    input  logic                 clr_err
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0]      DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0]      DIV_ZERO = DW'(0);
    localparam logic [DW-1:0]      DIV_ONE  = DW'(1);
    localparam logic [SW-1:0]      SC_ZERO  = SW'(0);
    localparam logic [SW-1:0]      SC_ONE   = SW'(1);
    localparam logic [SW-1:0]      SC_V0    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]      SC_V1    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0]      SC_V2    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0]      SC_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]      BIT_ZERO = BW'(0);
    localparam logic [BW-1:0]      BIT_ONE  = BW'(1);
    localparam logic [BW-1:0]      BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(0);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW + 1)'(0);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY  = 3'd3,
`endif
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic                 sync1_q, rxs_q;
    logic [DW-1:0]        div_q;
    logic                 tick_s, vote_s;
    state_t               state_q, state_d;
    logic [SW-1:0]        sc_q, sc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push_q, push_d;
    logic                 fe_set_s, pe_set_s, ov_set_s;
    logic                 frame_err_q, parity_err_q, overrun_q;
    logic [2:0]           sticky_q, sticky_d;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 pop_s, full_s, wr_en_s;

    assign tick_s = (div_q == DIV_LAST);
    assign vote_s = maj3(s0_q, s1_q, rxs_q);

    // Two-flop synchroniser; resets idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= serrx;
            rxs_q   <= sync1_q;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            div_q <= DIV_ZERO;
        end else if (tick_s) begin
            div_q <= DIV_ZERO;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    // Receiver state, sample and error-pulse registers.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sc_q         <= SC_ZERO;
            bit_q        <= BIT_ZERO;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            shreg_q      <= {DATA_BITS{1'b0}};
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            shreg_q      <= shreg_d;
            push_q       <= push_d;
            frame_err_q  <= fe_set_s;
            parity_err_q <= pe_set_s;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    // Frame FSM: all decisions are taken on oversample ticks.
    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        bit_d    = bit_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        shreg_d  = shreg_q;
        push_d   = 1'b0;
        fe_set_s = 1'b0;
        pe_set_s = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (tick_s) begin
            sc_d = (sc_q == SC_LAST) ? SC_ZERO : sc_q + SC_ONE;
            if (sc_q == SC_V0) s0_d = rxs_q; else s0_d = s0_q;
            if (sc_q == SC_V1) s1_d = rxs_q; else s1_d = s1_q;
            case (state_q)
                ST_IDLE: begin
                    // The detecting tick is sample 0 of the start bit.
                    if (!rxs_q) begin
                        state_d = ST_START;
                        sc_d    = SC_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        sc_d    = SC_ZERO;
                    end
                end
                ST_START: begin
                    if (sc_q == SC_V2 && vote_s) begin
                        state_d = ST_IDLE;
                        sc_d    = SC_ZERO;
                    end else if (sc_q == SC_LAST) begin
                        state_d = ST_DATA;
                        bit_d   = BIT_ZERO;
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (sc_q == SC_V2) shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
                    else shreg_d = shreg_q;
                    if (sc_q == SC_LAST && bit_q == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else if (sc_q == SC_LAST) begin
                        bit_d = bit_q + BIT_ONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    if (sc_q == SC_V2) par_bad_d = (vote_s != exp_parity(shreg_q));
                    else par_bad_d = par_bad_q;
                    if (sc_q == SC_LAST) state_d = ST_STOP;
                    else state_d = ST_PARITY;
                end
`endif
                ST_STOP: begin
                    if (sc_q == SC_V2) begin
                        if (vote_s) begin
                            // Back to IDLE right at the vote so a back-to-back start is caught.
                            state_d = ST_IDLE;
                            sc_d    = SC_ZERO;
`ifdef SERIAL_RX_PARITY_EN
                            push_d   = !par_bad_q;
                            pe_set_s = par_bad_q;
`else
                            push_d   = 1'b1;
`endif
                        end else begin
                            state_d  = ST_WAIT_HI;
                            fe_set_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_WAIT_HI: begin
                    sc_d = SC_ZERO;
                    if (rxs_q) state_d = ST_IDLE;
                    else state_d = ST_WAIT_HI;
                end
                default: begin
                    state_d = ST_IDLE;
                    sc_d    = SC_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign pop_s    = valid_q && rd_ready;
    assign full_s   = (count_q == CNT_FULL);
    assign wr_en_s  = push_q && (!full_s || pop_s);
    assign ov_set_s = push_q && full_s && !pop_s;

    // FIFO pointer/occupancy and sticky-error next state.
    always_comb begin
        wptr_d  = wr_en_s ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop_s ? rptr_q + PTR_ONE : rptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CNT_ZERO);
        if (clr_err) sticky_d = 3'b000;
        else sticky_d = sticky_q;
        sticky_d = sticky_d | {ov_set_s, pe_set_s, fe_set_s};
    end

    // FIFO control and error registers.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            wptr_q    <= PTR_ZERO;
            rptr_q    <= PTR_ZERO;
            count_q   <= CNT_ZERO;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            sticky_q  <= 3'b000;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            overrun_q <= ov_set_s;
            sticky_q  <= sticky_d;
        end
    end

    // FIFO storage; contents need no reset since rd_valid qualifies them.
    always_ff @(posedge clk25) begin
        if (wr_en_s) begin
            mem_q[wptr_q] <= shreg_q;
        end
    end

    assign rd_data    = mem_q[rptr_q];
    assign rd_valid   = valid_q;
    assign count      = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign err_sticky = sticky_q;

endmodule
